// File: rtl/smg_scan_receiver_pkg.sv
// Shared definitions for the 7-segment scan-bus receiver: digit count,
// segment bit positions, active-low segment codes and the FSM state type.
package smg_scan_receiver_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int SEG_DP     = 7;
   localparam int BUS_W      = NUM_DIGITS + 8;

   // Active-low segment codes {dp,g,f,e,d,c,b,a} with dp forced off
   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;
   localparam logic [7:0] SEG_A = 8'h88;
   localparam logic [7:0] SEG_B = 8'h83;
   localparam logic [7:0] SEG_C = 8'hC6;
   localparam logic [7:0] SEG_D = 8'hA1;
   localparam logic [7:0] SEG_E = 8'h86;
   localparam logic [7:0] SEG_F = 8'h8E;

   typedef enum logic [1:0] {
      WAIT_SCAN = 2'd0,
      SETTLE    = 2'd1,
      HOLD      = 2'd2
   } rx_state_t;

   // Exactly one strobe low (strobes are active-low)
   function automatic logic scan_valid(input logic [NUM_DIGITS-1:0] scan);
      logic [NUM_DIGITS-1:0] act;
      act = ~scan;
      return (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);
   endfunction

   // Index of the low strobe; only meaningful when scan_valid() holds
   function automatic logic [2:0] scan_slot(input logic [NUM_DIGITS-1:0] scan);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!scan[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/smg_scan_receiver_segment_decoder.sv
// Combinational decode of a 7-bit active-low segment pattern back to a hex
// nibble. Unknown patterns decode to F and raise err.
module smg_scan_receiver_segment_decoder
   import smg_scan_receiver_pkg::*;
(
   input  logic [6:0] seg_code,
   output logic [3:0] digit,
   output logic       err
);

   // Lookup with dp forced off so the dp segment never affects the digit
   always_comb begin
      digit = 4'hF;
      err   = 1'b0;
      case ({1'b1, seg_code})
         SEG_0:   digit = 4'h0;
         SEG_1:   digit = 4'h1;
         SEG_2:   digit = 4'h2;
         SEG_3:   digit = 4'h3;
         SEG_4:   digit = 4'h4;
         SEG_5:   digit = 4'h5;
         SEG_6:   digit = 4'h6;
         SEG_7:   digit = 4'h7;
         SEG_8:   digit = 4'h8;
         SEG_9:   digit = 4'h9;
         SEG_A:   digit = 4'hA;
         SEG_B:   digit = 4'hB;
         SEG_C:   digit = 4'hC;
         SEG_D:   digit = 4'hD;
         SEG_E:   digit = 4'hE;
         SEG_F:   digit = 4'hF;
         default: err   = 1'b1;
      endcase
   end

endmodule

// File: rtl/smg_scan_receiver.sv
// Capture side of the multiplexed 7-segment scan bus. Each strobed digit is
// sampled once after the bus has been stable long enough, decoded, and
// staged; a full set of six digits is published as one frame.
//
//  state     | meaning
//  WAIT_SCAN | no single digit strobed, idle
//  SETTLE    | one digit strobed, counting stable cycles before sampling
//  HOLD      | digit sampled, waiting for the bus to move on
module smg_scan_receiver
   import smg_scan_receiver_pkg::*;
#(
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  SMG_Data,
   input  logic [5:0]  Scan_Sig,
   output logic [23:0] Number_Sig,
   output logic [5:0]  DP_Sig,
   output logic        Frame_Valid,
   output logic        Seg_Err,
   output logic        Scan_Timeout
);

   localparam int SETTLE_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int TIMEOUT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [BUS_W-1:0]      sync_meta, sync_bus, snap;
   logic [NUM_DIGITS-1:0] cur_scan;
   logic [7:0]            cur_data;
   logic                  cur_valid, bus_changed, settle_done;
   logic                  snap_load, sample_en, frame_done;
   logic [SETTLE_W-1:0]   settle_cnt;
   logic [TIMEOUT_W-1:0]  timeout_cnt;
   logic [2:0]            slot;
   logic [3:0]            dec_digit;
   logic                  dec_err;
   logic [23:0]           stage_num;
   logic [5:0]            stage_dp, stage_err, mask;
   rx_state_t             state, state_nxt;

   assign cur_scan    = sync_bus[BUS_W-1:8];
   assign cur_data    = sync_bus[7:0];
   assign cur_valid   = scan_valid(cur_scan);
   assign bus_changed = (sync_bus != snap);
   assign settle_done = (settle_cnt == SETTLE_W'(SETTLE_CYC - 1));
   assign slot        = scan_slot(cur_scan);
   assign frame_done  = &mask;

   smg_scan_receiver_segment_decoder u_dec (
      .seg_code (cur_data[6:0]),
      .digit    (dec_digit),
      .err      (dec_err)
   );

   // Two-flop synchronizer on the whole scan/data bus
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_meta <= {{NUM_DIGITS{1'b1}}, 8'hFF};
         sync_bus  <= {{NUM_DIGITS{1'b1}}, 8'hFF};
      end else begin
         sync_meta <= {Scan_Sig, SMG_Data};
         sync_bus  <= sync_meta;
      end
   end

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= WAIT_SCAN;
      else     state <= state_nxt;
   end

   // FSM next-state logic; an invalid scan always wins so nothing is sampled on it
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_SCAN: if (cur_valid) state_nxt = SETTLE;
         SETTLE: begin
            if (!cur_valid)                       state_nxt = WAIT_SCAN;
            else if (!bus_changed && settle_done) state_nxt = HOLD;
         end
         HOLD: if (bus_changed) state_nxt = cur_valid ? SETTLE : WAIT_SCAN;
         default: state_nxt = WAIT_SCAN;
      endcase
   end

   // FSM outputs: snapshot reload and the single-cycle sample strobe
   always_comb begin
      snap_load = 1'b0;
      sample_en = 1'b0;
      case (state)
         WAIT_SCAN: snap_load = cur_valid;
         SETTLE: begin
            snap_load = cur_valid && bus_changed;
            sample_en = cur_valid && !bus_changed && settle_done;
         end
         HOLD:    snap_load = cur_valid && bus_changed;
         default: ;
      endcase
   end

   // Snapshot and settle counter; any bus change restarts the stability window
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         snap       <= '0;
         settle_cnt <= '0;
      end else if (snap_load) begin
         snap       <= sync_bus;
         settle_cnt <= '0;
      end else if (state == SETTLE && !settle_done) begin
         settle_cnt <= settle_cnt + SETTLE_W'(1);
      end
   end

   // Staging slots; the latest sample of a digit wins until the frame closes
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stage_num <= '0;
         stage_dp  <= '0;
         stage_err <= '0;
         mask      <= '0;
      end else if (frame_done) begin
         stage_err <= '0;
         mask      <= '0;
      end else if (sample_en) begin
         stage_num[{slot, 2'b00} +: 4] <= dec_digit;
         stage_dp[slot]                <= ~cur_data[SEG_DP];
         stage_err[slot]               <= dec_err;
         mask[slot]                    <= 1'b1;
      end
   end

   // Published frame registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Number_Sig  <= '0;
         DP_Sig      <= '0;
         Seg_Err     <= 1'b0;
         Frame_Valid <= 1'b0;
      end else begin
         Frame_Valid <= frame_done;
         if (frame_done) begin
            Number_Sig <= stage_num;
            DP_Sig     <= stage_dp;
            Seg_Err    <= |stage_err;
         end
      end
   end

   // Frame watchdog; restarts on the edge that publishes a frame and saturates
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         timeout_cnt  <= '0;
         Scan_Timeout <= 1'b0;
      end else if (frame_done) begin
         timeout_cnt  <= '0;
         Scan_Timeout <= 1'b0;
      end else if (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
         Scan_Timeout <= 1'b1;
      end else begin
         timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
      end
   end

endmodule

// File: tb/tb_smg_scan_receiver.sv
// Bench for the scan-bus receiver: directed scenarios plus randomized frames,
// all checked against a per-digit capture model held in plain arrays.
module tb_smg_scan_receiver;

   localparam int SETTLE_CYC  = 16;
   localparam int TIMEOUT_CYC = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  smg_data;
   logic [5:0]  scan_sig;
   logic [23:0] number_sig;
   logic [5:0]  dp_sig;
   logic        frame_valid, seg_err, scan_timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   smg_scan_receiver #(.SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .CLK          (clk),
      .RST          (rst),
      .SMG_Data     (smg_data),
      .Scan_Sig     (scan_sig),
      .Number_Sig   (number_sig),
      .DP_Sig       (dp_sig),
      .Frame_Valid  (frame_valid),
      .Seg_Err      (seg_err),
      .Scan_Timeout (scan_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   typedef struct {
      logic [23:0] num;
      logic [5:0]  dp;
      logic        err;
   } frame_t;

   frame_t     exp_q[$];
   frame_t     mon_f;
   logic [3:0] m_dig  [6];
   logic       m_dp   [6];
   logic       m_err  [6];
   logic       m_have [6];
   int         frames_exp = 0;
   int         frames_seen = 0;
   int         last_fv_cyc = 0;
   logic       fv_prev = 1'b0;

   function automatic logic [4:0] ref_decode(input logic [7:0] d);
      for (int i = 0; i < 16; i++)
         if (seg_tab[i] == {1'b1, d[6:0]}) return {1'b0, 4'(i)};
      return {1'b1, 4'hF};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 6; k++) begin
         m_have[k] = 1'b0;
         m_err[k]  = 1'b0;
      end
   endtask

   task automatic model_sample(input int slot, input logic [7:0] d);
      logic [4:0] r;
      bit         full;
      frame_t     f;
      r = ref_decode(d);
      m_dig[slot]  = r[3:0];
      m_err[slot]  = r[4];
      m_dp[slot]   = ~d[7];
      m_have[slot] = 1'b1;
      full = 1;
      for (int k = 0; k < 6; k++) if (!m_have[k]) full = 0;
      if (full) begin
         f.err = 1'b0;
         for (int k = 0; k < 6; k++) begin
            f.num[4*k +: 4] = m_dig[k];
            f.dp[k]         = m_dp[k];
            f.err           = f.err | m_err[k];
         end
         exp_q.push_back(f);
         frames_exp++;
         model_reset();
      end
   endtask

   // ---------------- frame monitor ----------------
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (frame_valid === 1'b1) begin
            frames_seen++;
            last_fv_cyc = cyc;
            chk("fv_pulse_width", {31'd0, fv_prev}, 32'd0);
            chk("timeout_at_frame", {31'd0, scan_timeout}, 32'd0);
            chk("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               mon_f = exp_q.pop_front();
               chk("frame_number", {8'd0, number_sig}, {8'd0, mon_f.num});
               chk("frame_dp", {26'd0, dp_sig}, {26'd0, mon_f.dp});
               chk("frame_err", {31'd0, seg_err}, {31'd0, mon_f.err});
            end
         end
         fv_prev = frame_valid;
      end else begin
         fv_prev = 1'b0;
      end
   end

   // ---------------- stimulus helpers (called just after a negedge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_pins(input logic [5:0] s, input logic [7:0] d);
      scan_sig = s;
      smg_data = d;
   endtask

   task automatic blank(input int n);
      set_pins(6'h3F, 8'hFF);
      idle(n);
   endtask

   task automatic strobe(input int slot, input logic [7:0] d, input int len);
      logic [5:0] s;
      s = ~(6'd1 << slot);
      model_sample(slot, d);
      set_pins(s, d);
      idle(len);
      blank(2);
   endtask

   task automatic strobe_glitch(input int slot, input logic [7:0] d, input int glitch_len);
      logic [5:0] s;
      s = ~(6'd1 << slot);
      set_pins(s, d);
      for (int i = 0; i < glitch_len; i++) begin
         smg_data = (i % 10 == 9) ? (d ^ 8'h10) : d;
         @(negedge clk);
      end
      model_sample(slot, d);
      smg_data = d;
      idle(40);
      blank(2);
   endtask

   function automatic logic [7:0] code_of(input logic [23:0] v, input int slot);
      logic [3:0] n;
      n = v[4*slot +: 4];
      return seg_tab[n];
   endfunction

   task automatic send_slots(input logic [23:0] v, input int lo, input int hi);
      for (int k = lo; k <= hi; k++) strobe(k, code_of(v, k), 40);
   endtask

   task automatic random_frame();
      int         start, n, slot, nmiss;
      int         miss [6];
      logic [7:0] d;
      start = frames_exp;
      n = 0;
      while (frames_exp == start) begin
         nmiss = 0;
         for (int k = 0; k < 6; k++) if (!m_have[k]) begin miss[nmiss] = k; nmiss++; end
         if (n >= 10 || $urandom_range(3) != 0) slot = miss[$urandom_range(nmiss - 1)];
         else                                   slot = $urandom_range(5);
         if ($urandom_range(3) == 0) d = 8'($urandom);
         else                        d = seg_tab[$urandom_range(15)] & {1'($urandom), 7'h7F};
         strobe(slot, d, $urandom_range(30, 45));
         blank($urandom_range(0, 2));
         n++;
      end
   endtask

   // ---------------- main sequence ----------------
   int lat;
   int seen0;

   initial begin
      rst = 1'b1;
      set_pins(6'h3F, 8'hFF);
      model_reset();
      idle(4);
      chk("rst_number", {8'd0, number_sig}, 32'd0);
      chk("rst_dp", {26'd0, dp_sig}, 32'd0);
      chk("rst_fv", {31'd0, frame_valid}, 32'd0);
      chk("rst_err", {31'd0, seg_err}, 32'd0);
      chk("rst_timeout", {31'd0, scan_timeout}, 32'd0);
      rst = 1'b0;
      idle(3);

      // 1: clean 123456 with latency on the closing digit
      send_slots(24'h123456, 0, 4);
      model_sample(5, code_of(24'h123456, 5));
      set_pins(~6'b100000, code_of(24'h123456, 5));
      @(posedge clk);
      lat = 0;
      while (frame_valid !== 1'b1 && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("t1_latency", lat, 2 + SETTLE_CYC + 1);
      @(negedge clk);
      idle(20);
      blank(2);
      chk("t1_number", {8'd0, number_sig}, 32'h123456);
      chk("t1_dp", {26'd0, dp_sig}, 32'd0);
      chk("t1_err", {31'd0, seg_err}, 32'd0);

      // 2: undecodable pattern with dp lit on digit 2, then a clean frame
      send_slots(24'h123456, 0, 1);
      strobe(2, 8'h7F, 40);
      send_slots(24'h123456, 3, 5);
      chk("t2_number", {8'd0, number_sig}, 32'h123F56);
      chk("t2_dp", {26'd0, dp_sig}, 32'h04);
      chk("t2_err", {31'd0, seg_err}, 32'd1);
      send_slots(24'h654321, 0, 5);
      chk("t2_clean_err", {31'd0, seg_err}, 32'd0);
      chk("t2_clean_number", {8'd0, number_sig}, 32'h654321);

      // 3: long strobe samples once, glitching digit delays the frame
      seen0 = frames_seen;
      strobe(0, code_of(24'h987654, 0), 40);
      strobe(1, code_of(24'h987654, 1), 200);
      strobe(2, code_of(24'h987654, 2), 40);
      strobe(4, code_of(24'h987654, 4), 40);
      strobe(5, code_of(24'h987654, 5), 40);
      chk("t3_no_early_frame", frames_seen - seen0, 0);
      strobe_glitch(3, code_of(24'h987654, 3), 200);
      chk("t3_one_frame", frames_seen - seen0, 1);
      chk("t3_number", {8'd0, number_sig}, 32'h987654);

      // 4: invalid scans do not sample and keep the partial frame
      seen0 = frames_seen;
      send_slots(24'hABCDEF, 0, 2);
      set_pins(6'b111100, seg_tab[7]);
      idle(100);
      set_pins(6'h3F, seg_tab[2]);
      idle(100);
      blank(2);
      chk("t4_no_frame", frames_seen - seen0, 0);
      send_slots(24'hABCDEF, 3, 5);
      chk("t4_frame", frames_seen - seen0, 1);
      chk("t4_number", {8'd0, number_sig}, 32'hABCDEF);

      // 5: timeout from last frame; partial digits survive it
      send_slots(24'h0A1B2C, 0, 2);
      blank(1);
      while (cyc < last_fv_cyc + TIMEOUT_CYC - 1) @(negedge clk);
      chk("t5_before_timeout", {31'd0, scan_timeout}, 32'd0);
      @(negedge clk);
      chk("t5_timeout", {31'd0, scan_timeout}, 32'd1);
      idle(50);
      chk("t5_timeout_held", {31'd0, scan_timeout}, 32'd1);
      send_slots(24'h0A1B2C, 3, 5);
      chk("t5_timeout_cleared", {31'd0, scan_timeout}, 32'd0);
      chk("t5_number", {8'd0, number_sig}, 32'h0A1B2C);

      // 6: reset mid-frame discards the partial frame
      send_slots(24'h314159, 0, 2);
      rst = 1'b1;
      model_reset();
      idle(3);
      chk("t6_rst_number", {8'd0, number_sig}, 32'd0);
      chk("t6_rst_dp", {26'd0, dp_sig}, 32'd0);
      chk("t6_rst_timeout", {31'd0, scan_timeout}, 32'd0);
      rst = 1'b0;
      idle(2);
      seen0 = frames_seen;
      send_slots(24'h314159, 3, 5);
      chk("t6_needs_all", frames_seen - seen0, 0);
      send_slots(24'h314159, 0, 2);
      chk("t6_frame", frames_seen - seen0, 1);
      chk("t6_number", {8'd0, number_sig}, 32'h314159);

      // randomized frames: arbitrary slot order, repeats, bad codes, dp
      for (int f = 0; f < 8; f++) random_frame();
      idle(30);

      chk("pending_frames", exp_q.size(), 0);
      chk("frame_count", frames_seen, frames_exp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #800_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
